// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Op encoding follows the RV32M funct3 field so decode needs no remapping.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(muldiv_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic op1_signed(muldiv_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic op2_signed(muldiv_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one product or quotient bit per clock,
// sign-magnitude datapath with a final negate step, valid/ready on both sides.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    muldiv_state_e  r_state;
    muldiv_op_e     r_op;
    logic [W-1:0]   r_mag1;
    logic [W-1:0]   r_mag2;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]   r_result;
    logic           r_out_valid;

    // Accept-side decode
    muldiv_op_e     w_op;
    logic           w_neg1;
    logic           w_neg2;
    logic [W-1:0]   w_mag1;
    logic [W-1:0]   w_mag2;
    logic           w_accept;
    logic           w_div_zero;
    logic           w_div_ovf;
    logic [W-1:0]   w_fast_result;

    assign w_op       = muldiv_op_e'(op[2:0]);
    assign w_neg1     = op1_signed(w_op) & op1[W-1];
    assign w_neg2     = op2_signed(w_op) & op2[W-1];
    assign w_mag1     = w_neg1 ? -op1 : op1;
    assign w_mag2     = w_neg2 ? -op2 : op2;
    assign w_accept   = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_div_zero = is_div(w_op) && (op2 == '0);
    assign w_div_ovf  = ((w_op == DIV) || (w_op == REM))
                        && (op1 == {1'b1, {(W-1){1'b0}}}) && (op2 == '1);
    assign w_fast_result = w_div_zero ? (is_rem(w_op) ? op1 : '1)
                                      : (is_rem(w_op) ? '0 : op1);

    // Multiply: shift-add, multiplier consumed from the low half of r_acc
    logic [W-1:0]   w_addend;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;

    assign w_addend   = r_acc[0] ? r_mag1 : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide: restoring; dividend shifts out of the low half as quotient bits shift in
    logic [W:0]     w_div_trial;
    logic           w_div_ge;
    logic [W-1:0]   w_div_rem;
    logic [2*W-1:0] w_div_next;

    assign w_div_trial = {r_rem, r_acc[W-1]};
    assign w_div_ge    = w_div_trial >= {1'b0, r_mag2};
    assign w_div_rem   = w_div_ge ? (w_div_trial[W-1:0] - r_mag2) : w_div_trial[W-1:0];
    assign w_div_next  = {r_acc[2*W-1:W], r_acc[W-2:0], w_div_ge};

    // Final sign fix-up and result selection
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem_fix;
    logic [W-1:0]   w_fix_result;

    assign w_prod    = r_neg_q ? -r_acc : r_acc;
    assign w_quot    = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    // NOTE: a default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_fix_result = '0;
        case (r_op)
            MUL:                 w_fix_result = w_prod[W-1:0];
            MULH, MULHSU, MULHU: w_fix_result = w_prod[2*W-1:W];
            DIV, DIVU:           w_fix_result = w_quot;
            default:             w_fix_result = w_rem_fix;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= MUL;
            r_mag1      <= '0;
            r_mag2      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_mag1  <= w_mag1;
                        r_mag2  <= w_mag2;
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_neg_r <= w_neg1;
                        r_acc   <= {{W{1'b0}}, is_div(w_op) ? w_mag1 : w_mag2};
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        if (w_div_zero || w_div_ovf) begin
                            r_result    <= w_fast_result;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (is_div(r_op)) begin
                            r_acc <= w_div_next;
                            r_rem <= w_div_rem;
                        end else begin
                            r_acc <= w_mul_next;
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(W - 1))
                            r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_result    <= w_fix_result;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Flush and consumer handshake both retire the result; result itself is kept.
                    if (flush || out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, handshake,
// flush/reset aborts, and random ops against a 64-bit arithmetic reference.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          busy;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [DW-1:0] last_exp;

    muldiv_unit #(.DATA_WIDTH(DW), .OP_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics via 64-bit signed/unsigned arithmetic.
    function automatic logic [31:0] ref_result(muldiv_op_e o, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0] pu;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        r  = '0;
        case (o)
            MUL:    begin p = sa * sb; r = p[31:0];  end
            MULH:   begin p = sa * sb; r = p[63:32]; end
            MULHSU: begin p = sa * ub; r = p[63:32]; end
            MULHU:  begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            DIV:    if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
            DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    if (b == 0) r = a;  else begin p = sa % sb; r = p[31:0]; end
            REMU:   r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Edges after the accept edge until out_valid is seen.
    function automatic int ref_latency(muldiv_op_e o, logic [31:0] a, logic [31:0] b);
        if ((o == DIVU || o == REMU) && b == 0) return 0;
        if ((o == DIV || o == REM) && (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 0;
        return DW + 1;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(muldiv_op_e o, logic [31:0] a, logic [31:0] b);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        op       = o;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < DW + 20) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(string tag, muldiv_op_e o, logic [31:0] a, logic [31:0] b,
                          logic [31:0] exp);
        int n;
        issue(o, a, b);
        wait_done(n);
        check({tag, "_latency"}, n, ref_latency(o, a, b));
        check({tag, "_result"}, result, exp);
        last_exp  = exp;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_retire"}, {out_valid, in_ready}, 2'b01);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int bad;
        muldiv_op_e ro;
        logic [31:0] ra, rb;

        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = '0; op1 = '0; op2 = '0;
        #1 rst = 1'b1;
        step();
        step();
        check("reset_outputs", {in_ready, out_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'h0});
        rst = 1'b0;
        step();

        // Multiply with latency and busy profile
        issue(MUL, 32'd7, 32'hFFFF_FFFD);
        n = 0; bad = 0;
        while (!out_valid && n < DW + 20) begin
            if (!busy) bad++;
            step();
            n++;
        end
        check("mul_latency", n, DW + 1);
        check("mul_busy_during_calc", bad, 0);
        check("mul_busy_done", busy, 1'b0);
        check("mul_result", result, 32'hFFFF_FFEB);

        // Backpressure: DONE holds
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'hFFFF_FFEB}) bad++;
        end
        check("backpressure_hold", bad, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("backpressure_release", {in_ready, out_valid}, 2'b10);

        run_op("mulh_minmin",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_ones",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_ones",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg",      DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_op("rem_neg",      REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_op("divu_100_7",   DIVU,   32'd100,       32'd7,         32'd14);
        run_op("remu_100_7",   REMU,   32'd100,       32'd7,         32'd2);
        run_op("div_by_zero",  DIV,    32'd5,         32'd0,         32'hFFFF_FFFF);
        run_op("rem_by_zero",  REM,    32'd5,         32'd0,         32'd5);
        run_op("div_overflow", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_overflow", REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op("remu_known",   REMU,   32'd23,        32'd5,         32'd3);

        // Flush in CALC after 10 iterations
        issue(MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_calc_state", {in_ready, out_valid, busy}, 3'b100);
        check("flush_calc_result_kept", result, last_exp);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) bad++;
        end
        check("flush_calc_no_valid", bad, 0);
        run_op("after_flush", MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_result(MULHU, 32'h1234_5678, 32'h9ABC_DEF0));

        // Flush in IDLE suppresses accept (fast-path op would show at once)
        op = DIV; op1 = 32'd5; op2 = 32'd0;
        in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_no_accept", {in_ready, out_valid, busy}, 3'b100);

        // Flush beats out_ready in DONE
        issue(DIVU, 32'd100, 32'd7);
        wait_done(n);
        check("flush_done_reached", out_valid, 1'b1);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_state", {in_ready, out_valid}, 2'b10);
        check("flush_done_result_kept", result, 32'd14);

        // Asynchronous reset mid-CALC
        issue(MUL, 32'd3, 32'd5);
        for (int i = 0; i < 5; i++) step();
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {in_ready, out_valid, busy, result},
                 {1'b1, 1'b0, 1'b0, 32'h0});
        #1 rst = 1'b0;
        step();
        run_op("after_reset", DIV, 32'hFFFF_FF9C, 32'd7, ref_result(DIV, 32'hFFFF_FF9C, 32'd7));

        // Random ops against the reference
        for (int i = 0; i < 40; i++) begin
            ro = muldiv_op_e'(3'($urandom_range(0, 7)));
            ra = pick();
            rb = pick();
            run_op($sformatf("rand%0d_%s", i, ro.name()), ro, ra, rb, ref_result(ro, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
